apb3_requester_arbiter: RTL
===========================

Name: apb3_requester_arbiter

Overview:
APB3 master-side arbiter and sequencer that shares one APB3 completer bus between NumRequesters local requesters. It accepts one request at a time from a round-robin winner and drives the SETUP/ACCESS phase sequence. It returns read data and the error status to the winning requester. It sits between the bus-bridge requesters and the APB3 interface, and adds a response timeout so that a hung completer cannot stall the bus.

Parameters:
NumRequesters, 2, number of requesters (1..8)
AddressWidth, 20, APB paddr width
DataWidth, 32, APB data width; legal values {8,16,24,32}; elaboration error otherwise
TimeoutCycles, 16, maximum ACCESS cycles without pready before forced error completion (>=2)

Ports:
pclk  input  1  bus clock
presetn  input  1  synchronous active-low reset
req_valid  input  NumRequesters  per-requester transfer request
req_ready  output  NumRequesters  one-hot accept pulse
req_write  input  NumRequesters  1 = write
req_addr  input  NumRequesters*AddressWidth  packed addresses, requester i at [i*AW +: AW]
req_wdata  input  NumRequesters*DataWidth  packed write data
rsp_valid  output  NumRequesters  one-hot completion pulse
rsp_rdata  output  DataWidth  read data, shared, valid with rsp_valid
rsp_error  output  1  pslverr or timeout, valid with rsp_valid
paddr  output  AddressWidth  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DataWidth  APB write data
pready  input  1  completer ready
prdata  input  DataWidth  completer read data
pslverr  input  1  completer error

Behaviour:
- Clock and reset: one clock, pclk. presetn is synchronous and active-low; it is sampled on the pclk rising edge.
- Reset values: FSM=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rr pointer=0 (requester 0 highest priority), timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is set, pick the winner by round-robin. The search starts at the rr pointer and wraps modulo NumRequesters.
  - req_ready[winner] is combinational and is high during this IDLE cycle only.
  - Capture addr/write/wdata into the APB output registers.
  - Set the rr pointer to winner+1, wrapping to 0 after NumRequesters-1.
  - Next state is SETUP. With no request, stay in IDLE.
- SETUP: psel=1, penable=0, with paddr/pwrite/pwdata stable. Always go to ACCESS next cycle.
- ACCESS: psel=1, penable=1; the timeout counter increments each cycle.
  - If pready=1, complete: the next cycle is IDLE and rsp_valid[winner]=1 for exactly that cycle.
    - rsp_rdata = prdata when the transfer is a read; hold the previous value on writes.
    - rsp_error = pslverr.
  - If pready=0 and counter == TimeoutCycles-1, force completion: next IDLE, rsp_valid[winner]=1, rsp_error=1, rsp_rdata=0.
  - The counter clears on entry to SETUP.
- Outputs in IDLE: psel=0, penable=0. paddr/pwdata/pwrite hold their last values in IDLE.
- Throughput: at most one transfer per 3 cycles with zero wait states (IDLE, SETUP, ACCESS). A new grant may occur in the same IDLE cycle that carries rsp_valid for the previous transfer.
- Requester obligations: a requester holds req_valid/addr/write/wdata stable until req_ready. Deasserting req_valid before the grant is legal, and the request is then dropped. The arbiter ignores req_valid of the current winner while a transfer is outstanding. Only one transfer is outstanding at a time.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others wait with req_ready=0.
- Contents of pslverr/prdata are ignored unless psel&penable&pready.
- Reset mid-transfer: on presetn=0 in any state, all outputs go to reset values at the next edge. No rsp_valid is issued for the aborted transfer.

Test Plan:
- Single write, zero wait: req 0 writes 0xDEADBEEF to 0x00010. Required: SETUP at cycle+1, ACCESS at cycle+2 with pready=1, rsp_valid[0] at cycle+3, rsp_error=0.
- Read with 3 wait states: req 1 reads 0x00020; pready rises on the 4th ACCESS cycle with prdata=0x12345678. Required: rsp_rdata=0x12345678 and the pulse lasts one cycle.
- Round-robin fairness: both requesters hold valid for 4 transfers. Required grant order 0,1,0,1, each IDLE→SETUP→ACCESS with no idle gaps beyond the IDLE cycle.
- Slave error: pslverr=1 with pready=1 on a write. Required: rsp_error=1, rsp_valid for the correct requester, and the next transfer starts normally.
- Timeout: pready is held 0 with TimeoutCycles=16. Required: after 16 ACCESS cycles psel drops, rsp_error=1, rsp_rdata=0.
- Reset mid-ACCESS: assert presetn=0 for 1 cycle. Required: psel/penable=0 the next cycle, no rsp_valid, rr pointer=0, and requester 0 wins the next simultaneous request.

Source files
------------

// File: rtl/apb3_requester_arbiter.sv
// apb3_requester_arbiter: round-robin arbiter sequencing one APB3 transfer at a time, with ACCESS timeout
module apb3_requester_arbiter #(
    parameter int NumRequesters = 2,
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                                  pclk,
    input  logic                                  presetn,
    input  logic [NumRequesters-1:0]              req_valid,
    output logic [NumRequesters-1:0]              req_ready,
    input  logic [NumRequesters-1:0]              req_write,
    input  logic [NumRequesters*AddressWidth-1:0] req_addr,
    input  logic [NumRequesters*DataWidth-1:0]    req_wdata,
    output logic [NumRequesters-1:0]              rsp_valid,
    output logic [DataWidth-1:0]                  rsp_rdata,
    output logic                                  rsp_error,
    output logic [AddressWidth-1:0]               paddr,
    output logic                                  psel,
    output logic                                  penable,
    output logic                                  pwrite,
    output logic [DataWidth-1:0]                  pwdata,
    input  logic                                  pready,
    input  logic [DataWidth-1:0]                  prdata,
    input  logic                                  pslverr
);
    localparam int PW = NumRequesters > 1 ? $clog2(NumRequesters) : 1;
    localparam int CW = $clog2(TimeoutCycles + 1);

    if (DataWidth % 8 != 0 || DataWidth < 8 || DataWidth > 32) begin : g_bad_width
        $error("DataWidth must be 8, 16, 24 or 32");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] ptr, cur, off, win;
    logic [PW:0] sum;
    logic [2*NumRequesters-1:0] dbl;
    logic [NumRequesters-1:0] rot;
    logic [CW-1:0] cnt;
    logic any, done;

    // Rotate requests so the rr pointer lands at bit 0, then take the lowest set offset
    assign dbl = {req_valid, req_valid} >> ptr;
    assign rot = dbl[NumRequesters-1:0];
    assign any = |req_valid;
    always_comb begin
        off = '0;
        for (int i = NumRequesters - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
    end
    assign sum  = {1'b0, ptr} + {1'b0, off};
    assign win  = sum >= (PW+1)'(NumRequesters) ? PW'(sum - (PW+1)'(NumRequesters)) : PW'(sum);
    assign done = state == ACCESS && (pready || cnt == CW'(TimeoutCycles - 1));

    always_ff @(posedge pclk)
        state <= !presetn ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state == IDLE  ? (any ? SETUP : IDLE) :
                    state == SETUP ? ACCESS : (done ? IDLE : ACCESS);
    end

    always_comb begin
        psel      = state != IDLE;
        penable   = state == ACCESS;
        req_ready = (state == IDLE && any) ? NumRequesters'(1) << win : '0;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ptr       <= '0;
            cur       <= '0;
            cnt       <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            cnt       <= state == ACCESS ? cnt + CW'(1) : '0;
            rsp_valid <= done ? NumRequesters'(1) << cur : '0;
            if (state == IDLE && any) begin
                cur    <= win;
                ptr    <= win == PW'(NumRequesters - 1) ? '0 : win + PW'(1);
                paddr  <= req_addr[win*AddressWidth +: AddressWidth];
                pwrite <= req_write[win];
                pwdata <= req_wdata[win*DataWidth +: DataWidth];
            end
            // A timeout completes as an error with zeroed read data
            if (done) begin
                rsp_error <= pready ? pslverr : 1'b1;
                rsp_rdata <= !pready ? '0 : pwrite ? rsp_rdata : prdata;
            end
        end
    end
endmodule
